// File: rtl/digit_scan_driver.sv
// Six-digit common-anode seven-segment scanner. Each frame works from a snapshot
// of the BCD bus, with optional hidden masking and leading-zero blanking.
module digit_scan_driver #(
    parameter int PRESCALE = 4,
    parameter bit LZB      = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    input  logic       hidden,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    idx_reg, idx_next;
    logic [3:0]    snap_reg [6];
    logic          snap_hidden_reg;
    logic [5:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          frame_tick_reg;

    logic          tick;
    logic          wrap;
    logic [3:0]    din   [6];
    logic [3:0]    cur_d [6];
    logic          cur_hidden;
    logic [5:0]    is_zero;
    logic [5:0]    blank;
    logic [3:0]    sel_digit;
    logic          sel_blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign din[0] = d1;
    assign din[1] = d2;
    assign din[2] = d3;
    assign din[3] = d4;
    assign din[4] = d5;
    assign din[5] = d6;

    assign tick = (presc_reg == PRESC_LAST);
    assign wrap = tick && (idx_reg == 3'd5);

    // On the wrap edge decode straight from the bus so the first digit of the
    // new frame already reflects the values being captured.
    assign cur_hidden = wrap ? hidden : snap_hidden_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign cur_d[gi]   = wrap ? din[gi] : snap_reg[gi];
            assign is_zero[gi] = (cur_d[gi] == 4'd0);
            if (gi < 5) begin : g_lzb
                // A digit is a leading zero only if it and every digit to its left are exactly 0.
                assign blank[gi] = LZB && (&is_zero[gi:0]);
            end else begin : g_last
                assign blank[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state logic: prescaler and scan index.
    always_comb begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        idx_next   = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    // Output logic for the position being entered.
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        case (idx_next)
            3'd0: begin sel_digit = cur_d[0]; sel_blank = blank[0]; end
            3'd1: begin sel_digit = cur_d[1]; sel_blank = blank[1]; end
            3'd2: begin sel_digit = cur_d[2]; sel_blank = blank[2]; end
            3'd3: begin sel_digit = cur_d[3]; sel_blank = blank[3]; end
            3'd4: begin sel_digit = cur_d[4]; sel_blank = blank[4]; end
            3'd5: begin sel_digit = cur_d[5]; sel_blank = blank[5]; end
            default: begin sel_digit = 4'd0; sel_blank = 1'b1; end
        endcase

        an_next = ~(6'b000001 << idx_next);
        if (cur_hidden) begin
            seg_next = SEG_DASH;
        end else if (sel_blank) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = bcd_to_seg(sel_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_reg       <= '0;
            idx_reg         <= 3'd5;
            for (int i = 0; i < 6; i++) begin
                snap_reg[i] <= 4'd0;
            end
            snap_hidden_reg <= 1'b0;
            an_reg          <= 6'b111111;
            seg_reg         <= SEG_BLANK;
            frame_tick_reg  <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            frame_tick_reg <= wrap;
            if (tick) begin
                idx_reg <= idx_next;
                an_reg  <= an_next;
                seg_reg <= seg_next;
            end
            if (wrap) begin
                for (int i = 0; i < 6; i++) begin
                    snap_reg[i] <= din[i];
                end
                snap_hidden_reg <= hidden;
            end
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver: three instances (PRESCALE=4 with and
// without blanking, PRESCALE=1) share the stimulus; expected patterns are hand tables.
module tb_digit_scan_driver;

    logic       clk;
    logic       reset_n;
    logic [3:0] d1, d2, d3, d4, d5, d6;
    logic       hidden;
    logic [5:0] an_l, an_n, an_f;
    logic [6:0] seg_l, seg_n, seg_f;
    logic       ft_l, ft_n, ft_f;

    int n_cmp = 0;
    int n_mis = 0;

    digit_scan_driver #(.PRESCALE(4), .LZB(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .hidden(hidden), .an(an_l), .seg(seg_l), .frame_tick(ft_l)
    );

    digit_scan_driver #(.PRESCALE(4), .LZB(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .hidden(hidden), .an(an_n), .seg(seg_n), .frame_tick(ft_n)
    );

    digit_scan_driver #(.PRESCALE(1), .LZB(1'b1)) dut_f (
        .clk(clk), .reset_n(reset_n),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .hidden(hidden), .an(an_f), .seg(seg_f), .frame_tick(ft_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low one-hot digit enables for idx 0..5.
    logic [5:0] an_tab [6] = '{6'b111110, 6'b111101, 6'b111011,
                               6'b110111, 6'b101111, 6'b011111};

    // Expected seg per frame (0..6) and position: frames 0,1,3 = {0,0,0,0,2,0},
    // frame 2 = hidden, frame 4 = {0,0,12,0,0,7}, frames 5,6 = all zero.
    logic [6:0] exp_l [7][6] = '{
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40},
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40},
        '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F},
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40},
        '{7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h78},
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
        '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}
    };
    logic [6:0] exp_n [7][6] = '{
        '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h40},
        '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h40},
        '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F},
        '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h40},
        '{7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h78},
        '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
        '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}
    };

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        d1 = a; d2 = b; d3 = c; d4 = d; d5 = e; d6 = f;
    endtask

    initial begin
        int f;
        int ix;
        int c2;

        reset_n = 1'b0;
        hidden  = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0);

        step();
        step();
        $display("reset: an_l=%b seg_l=%b ft_l=%b", an_l, seg_l, ft_l);
        check("reset_an_l",  {1'b0, an_l}, 7'h3F);
        check("reset_seg_l", seg_l, 7'h7F);
        check("reset_ft_l",  {6'b0, ft_l}, 7'h00);
        check("reset_an_n",  {1'b0, an_n}, 7'h3F);
        check("reset_seg_n", seg_n, 7'h7F);
        check("reset_an_f",  {1'b0, an_f}, 7'h3F);
        check("reset_seg_f", seg_f, 7'h7F);
        check("reset_ft_f",  {6'b0, ft_f}, 7'h00);

        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            $display("pre-tick edge %0d: an_l=%b seg_l=%b ft_l=%b", k, an_l, seg_l, ft_l);
            check("pretick_an_l",  {1'b0, an_l}, 7'h3F);
            check("pretick_seg_l", seg_l, 7'h7F);
            check("pretick_ft_l",  {6'b0, ft_l}, 7'h00);
        end

        // Main scan: edge c=0 is the first wrap; frames are 24 edges long.
        for (int c = 0; c <= 157; c++) begin
            step();
            f  = c / 24;
            ix = (c / 4) % 6;
            $display("scan c=%0d frame=%0d idx=%0d: an_l=%b seg_l=%b ft_l=%b seg_n=%b",
                     c, f, ix, an_l, seg_l, ft_l, seg_n);
            check("scan_an_l",  {1'b0, an_l}, {1'b0, an_tab[ix]});
            check("scan_seg_l", seg_l, exp_l[f][ix]);
            check("scan_ft_l",  {6'b0, ft_l}, {6'b0, (c % 24) == 0});
            check("scan_an_n",  {1'b0, an_n}, {1'b0, an_tab[ix]});
            check("scan_seg_n", seg_n, exp_n[f][ix]);
            check("scan_ft_n",  {6'b0, ft_n}, {6'b0, (c % 24) == 0});

            if (c == 30) hidden = 1'b1;
            if (c == 60) hidden = 1'b0;
            if (c == 95) set_digits(4'd0, 4'd0, 4'd12, 4'd0, 4'd0, 4'd7);
            if (c == 119) set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
            if (c == 40) set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
            if (c == 47) set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0);
            if (c == 157) reset_n = 1'b0;
        end

        // One-cycle reset in the middle of idx3 blanks everything on the next edge.
        step();
        $display("mid-reset: an_l=%b seg_l=%b ft_l=%b an_f=%b", an_l, seg_l, ft_l, an_f);
        check("midrst_an_l",  {1'b0, an_l}, 7'h3F);
        check("midrst_seg_l", seg_l, 7'h7F);
        check("midrst_ft_l",  {6'b0, ft_l}, 7'h00);
        check("midrst_an_f",  {1'b0, an_f}, 7'h3F);
        check("midrst_seg_f", seg_f, 7'h7F);
        reset_n = 1'b1;

        // Restart: PRESCALE=4 waits 4 edges, PRESCALE=1 ticks every edge.
        for (int k = 1; k <= 12; k++) begin
            step();
            $display("restart k=%0d: an_l=%b seg_l=%b ft_l=%b an_f=%b seg_f=%b ft_f=%b",
                     k, an_l, seg_l, ft_l, an_f, seg_f, ft_f);
            if (k < 4) begin
                check("restart_an_l",  {1'b0, an_l}, 7'h3F);
                check("restart_seg_l", seg_l, 7'h7F);
                check("restart_ft_l",  {6'b0, ft_l}, 7'h00);
            end else begin
                c2 = k - 4;
                check("restart_an_l",  {1'b0, an_l}, {1'b0, an_tab[c2 / 4]});
                check("restart_seg_l", seg_l, exp_l[5][c2 / 4]);
                check("restart_ft_l",  {6'b0, ft_l}, {6'b0, c2 == 0});
            end
            ix = (k - 1) % 6;
            check("fast_an_f",  {1'b0, an_f}, {1'b0, an_tab[ix]});
            check("fast_seg_f", seg_f, exp_l[5][ix]);
            check("fast_ft_f",  {6'b0, ft_f}, {6'b0, ix == 0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
